imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle RV32I core fetches and decodes from.
- Accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses and checks an XOR checksum.
- Holds the core in reset until a load completes cleanly.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  instruction-memory word address
imem_wdata  output  32  assembled instruction word
core_rst  output  1  reset to the RV32I core; high while not loaded
load_done  output  1  level: last load succeeded
load_err  output  1  level: last load failed

Behaviour:
- Interface:
  - One clock domain (clk). Reset is synchronous and active-high (rst).
  - Byte accepted on a clk edge where in_valid && in_ready. in_ready = !rst, so it is 1 in every state; the loader never stalls.
- Reset values: state WAIT_SYNC, in_ready 0 (during rst), imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, load_done 0, load_err 0, internal counters and checksum 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*LEN data bytes (little-endian words: first byte -> [7:0]), then one CHK byte.
  - LEN is a 16-bit word count.
  - CHK is the XOR of all data bytes only; sync and LEN bytes are excluded.
- States and transitions (all transitions on accepted bytes only):
  - WAIT_SYNC: SYNC_BYTE -> LEN_LO. Any other byte is discarded.
  - LEN_LO: store the low length byte -> LEN_HI.
  - LEN_HI: store the high length byte, then branch:
    - LEN > 2^ADDR_WIDTH -> ERROR.
    - LEN == 0 -> CHECK.
    - Otherwise -> DATA.
  - DATA: shift the byte into the word assembler and XOR it into the checksum. On the 4th byte of a word:
    - On the next cycle: imem_we = 1 for exactly one cycle, imem_wdata = assembled word, imem_addr = current word index.
    - Word index then increments; remaining count decrements.
    - Last word -> CHECK.
  - CHECK: byte == checksum -> DONE, otherwise -> ERROR.
  - DONE: core_rst = 0, load_done = 1, load_err = 0. SYNC_BYTE -> LEN_LO (reload). Other bytes are discarded.
  - ERROR: core_rst = 1, load_err = 1, load_done = 0. SYNC_BYTE -> LEN_LO (retry). Other bytes are discarded.
- Entering LEN_LO from any state:
  - core_rst -> 1; load_done and load_err -> 0.
  - Word index, byte lane and checksum are cleared.
- Write timing and output registers:
  - Write latency is one cycle after the accepting edge of the 4th byte.
  - All outputs except in_ready are registered.
  - imem_addr and imem_wdata hold their last values when imem_we = 0.
- Boundaries:
  - LEN == 2^ADDR_WIDTH is legal: the last write lands at the all-ones address and the index wraps to 0 internally, unused.
  - A LEN_HI value of 0 with LEN_LO of 0 goes straight to CHECK, which expects 8'h00.
  - Words written before a checksum error stay in memory; core_rst stays 1.
  - A SYNC_BYTE value inside DATA or CHECK is treated as data, not a resync.
  - rst mid-frame aborts immediately to the reset values. The next frame writes from address 0.
  - in_valid gaps between any bytes are tolerated with no timeout.

Decomposition:
- Shared package holds:
  - State encoding constants: WAIT_SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - SYNC_BYTE default.
  - Byte-lane width constants.
- One natural sub-module: imem_word_assembler.
  - Contains the 2-bit byte lane counter and the 32-bit shift/merge register.
  - Outputs word_valid and word.
- The FSM, address counter and checksum live in imem_loader.

Test Plan:
1. A5 02 00 13 05 A0 00 93 05 10 00 30 -> writes addr 0 = 32'h00A00513, then addr 1 = 32'h00100593, each imem_we a single-cycle pulse one cycle after the 4th byte; then load_done=1, core_rst=0, load_err=0.
2. Same frame with CHK=31 -> both words written; load_err=1, core_rst=1, load_done=0. A following correct frame -> load_done=1.
3. A5 00 00 00 -> no imem_we; DONE. Same frame with CHK=01 -> ERROR.
4. ADDR_WIDTH=8, A5 01 01 (LEN=257) -> ERROR on the LEN_HI byte, no writes. LEN=256 with correct checksum -> last write at addr 8'hFF, DONE.
5. Bytes 11 22 A5 01 00 EF BE AD DE with in_valid deasserted 3 cycles between each, then CHK -> 11 and 22 ignored; one write of 32'hDEADBEEF to addr 0; DONE when CHK=22 (XOR EF^BE^AD^DE).
6. rst asserted one cycle after the 2nd data byte -> all outputs at reset values next cycle; a fresh frame writes starting at addr 0 with its own checksum.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encodings and framing constants shared by the instruction-memory loader.
package imem_loader_pkg;
  localparam logic [2:0] WAIT_SYNC = 3'd0;
  localparam logic [2:0] LEN_LO    = 3'd1;
  localparam logic [2:0] LEN_HI    = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int WORD_W = BYTE_W * LANES;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);
  import imem_loader_pkg::*;
  logic                  in_valid;
  logic [BYTE_W-1:0]     in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [WORD_W-1:0]     imem_wdata;
  modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs four bytes little-endian into a word, pulsing word_valid the cycle after the 4th.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_end,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] shift_q, shift_d, word_q, word_d;
  logic              valid_q, valid_d;
  always_comb begin
    word_end = byte_valid && lane_q == LANE_W'(LANES - 1);
    shift_d  = clr ? '0 : byte_valid ? {byte_in, shift_q[WORD_W-1:BYTE_W]} : shift_q;
    lane_d   = clr ? '0 : byte_valid ? lane_q + 1'b1 : lane_q;
    valid_d  = word_end;
    word_d   = word_end ? shift_d : word_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end
  assign word_valid = valid_q;
  assign word       = word_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing the RV32I instruction memory and gating core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         load_done,
  output logic         load_err
);
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;
  logic [2:0]            state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d, csum_q, csum_d;
  logic [15:0]           rem_q, rem_d, len;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic                  core_rst_q, core_rst_d, done_q, done_d, err_q, err_d;
  logic                  acc, data_acc, clr, word_end, word_valid;
  logic [WORD_W-1:0]     word;
  assign acc      = bus.in_valid && bus.in_ready;
  assign data_acc = acc && state_q == DATA;
  assign clr      = acc && bus.in_data == SYNC_BYTE &&
                    (state_q == WAIT_SYNC || state_q == DONE || state_q == ERROR);
  imem_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .byte_valid (data_acc),
    .byte_in    (bus.in_data),
    .word_end   (word_end),
    .word_valid (word_valid),
    .word       (word)
  );
  always_comb begin
    len      = {bus.in_data, len_lo_q};
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    if (clr) begin
      state_d = LEN_LO;
      idx_d   = '0;
      csum_d  = '0;
    end else if (acc) begin
      case (state_q)
        LEN_LO: begin
          len_lo_d = bus.in_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          rem_d   = len;
          state_d = {1'b0, len} > CAP ? ERROR : len == 16'd0 ? CHECK : DATA;
        end
        DATA: begin
          csum_d = csum_q ^ bus.in_data;
          if (word_end) begin
            addr_d  = idx_q;
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = rem_q == 16'd1 ? CHECK : DATA;
          end
        end
        CHECK:                   state_d = bus.in_data == csum_q ? DONE : ERROR;
        WAIT_SYNC, DONE, ERROR:  state_d = state_q;
        default:                 state_d = WAIT_SYNC;
      endcase
    end
    // status flags follow the state being entered so they stay registered
    core_rst_d = state_d != DONE;
    done_d     = state_d == DONE;
    err_d      = state_d == ERROR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_SYNC;
      len_lo_q   <= '0;
      csum_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      csum_q     <= csum_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign bus.in_ready   = !rst;
  assign bus.imem_we    = word_valid;
  assign bus.imem_wdata = word;
  assign bus.imem_addr  = addr_q;
  assign core_rst       = core_rst_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with hand-computed writes, checksums and status flags.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, load_done, load_err;
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int w0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [7:0]  f1 [11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  imem_loader_if #(.ADDR_WIDTH(8)) bus ();
  imem_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= bus.imem_addr;
      last_data <= bus.imem_wdata;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic status(input string tag, input logic d, input logic e, input logic c);
    chk({tag, ".done"}, load_done, d);
    chk({tag, ".err"}, load_err, e);
    chk({tag, ".core_rst"}, core_rst, c);
  endtask
  task automatic frame1(input logic [7:0] chk_b);
    foreach (f1[i]) send(f1[i]);
    send(chk_b);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    idle(2);
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.we", bus.imem_we, 0);
    chk("rst.addr", bus.imem_addr, 0);
    chk("rst.wdata", bus.imem_wdata, 0);
    status("rst", 0, 0, 1);
    rst = 1'b0;
    idle(1);
    chk("in_ready", bus.in_ready, 1);
    // test 1: two-word frame, write timing
    for (int i = 0; i < 7; i++) send(f1[i]);
    chk("t1.w0.we", bus.imem_we, 1);
    chk("t1.w0.addr", bus.imem_addr, 0);
    chk("t1.w0.data", bus.imem_wdata, 32'h00A00513);
    send(8'h93);
    chk("t1.pulse", bus.imem_we, 0);
    send(8'h05);
    send(8'h10);
    send(8'h00);
    chk("t1.w1.we", bus.imem_we, 1);
    chk("t1.w1.addr", bus.imem_addr, 1);
    chk("t1.w1.data", bus.imem_wdata, 32'h00100593);
    send(8'h30);
    status("t1", 1, 0, 0);
    chk("t1.hold.we", bus.imem_we, 0);
    chk("t1.hold.addr", bus.imem_addr, 1);
    chk("t1.hold.data", bus.imem_wdata, 32'h00100593);
    // test 2: bad checksum keeps written words, then retry
    w0 = wr_cnt;
    frame1(8'h31);
    chk("t2.writes", wr_cnt - w0, 2);
    status("t2.bad", 0, 1, 1);
    send(8'h30);
    status("t2.discard", 0, 1, 1);
    frame1(8'h30);
    status("t2.retry", 1, 0, 0);
    // test 3: zero-length frame
    w0 = wr_cnt;
    send(8'hA5);
    status("t3.reload", 0, 0, 1);
    send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    chk("t3.nowrite", wr_cnt - w0, 0);
    status("t3.ok", 1, 0, 0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    status("t3.bad", 0, 1, 1);
    // test 4: length bounds
    w0 = wr_cnt;
    send(8'hA5); send(8'h01); send(8'h01);
    status("t4.257", 0, 1, 1);
    idle(2);
    chk("t4.257.nowrite", wr_cnt - w0, 0);
    send(8'hA5); send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
    end
    send(8'h00);
    chk("t4.256.writes", wr_cnt - w0, 256);
    chk("t4.256.addr", last_addr, 8'hFF);
    chk("t4.256.data", last_data, 32'h000000FF);
    status("t4.256", 1, 0, 0);
    // test 5: junk before sync and in_valid gaps
    w0 = wr_cnt;
    send(8'h11); idle(3);
    send(8'h22); idle(3);
    status("t5.junk", 1, 0, 0);
    send(8'hA5); idle(3);
    send(8'h01); idle(3);
    send(8'h00); idle(3);
    send(8'hEF); idle(3);
    send(8'hBE); idle(3);
    send(8'hAD); idle(3);
    send(8'hDE);
    chk("t5.we", bus.imem_we, 1);
    chk("t5.addr", bus.imem_addr, 0);
    chk("t5.data", bus.imem_wdata, 32'hDEADBEEF);
    idle(3);
    send(8'h22);
    chk("t5.writes", wr_cnt - w0, 1);
    status("t5", 1, 0, 0);
    // test 6: reset mid-frame
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAA); send(8'hBB);
    rst = 1'b1;
    idle(1);
    chk("t6.in_ready", bus.in_ready, 0);
    chk("t6.we", bus.imem_we, 0);
    chk("t6.addr", bus.imem_addr, 0);
    chk("t6.wdata", bus.imem_wdata, 0);
    status("t6.rst", 0, 0, 1);
    rst = 1'b0;
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    chk("t6.we2", bus.imem_we, 1);
    chk("t6.addr2", bus.imem_addr, 0);
    chk("t6.data2", bus.imem_wdata, 32'h11223344);
    send(8'h44);
    status("t6.ok", 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
